// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam int         MD_CNT_W = 4;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    // Clear beats increment when both arrive in the same cycle.
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            q_reg <= '0;
        end else if (inc && (q_reg != {W{1'b1}})) begin
            q_reg <= q_reg + W'(1);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall / bubble / flush sequencing for the 5-stage core: load-use, multi-cycle
// mult/div occupancy of EX, and taken-branch flush resolved in MEM.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic [4:0]       id_ex_rt_i,
    input  logic             id_ex_memread_i,
    input  logic             md_start_i,
    input  logic             branch_taken_i,
    input  logic             cnt_clr_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             id_ex_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic             md_done_o,
    output logic             md_abort_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [MD_CNT_W-1:0] MD_RELOAD = MD_CNT_W'(MD_LAT - 2);

    state_t              state_reg;
    logic [MD_CNT_W-1:0] md_cnt_reg;
    logic                in_busy;
    logic                load_use;

    assign in_busy = (state_reg == MD_BUSY);

    // $0 is never a real dependency, so a load targeting it cannot stall.
    assign load_use = id_ex_memread_i && (id_ex_rt_i != REG_ZERO) &&
                      ((id_ex_rt_i == id_rs_i) ||
                       (id_uses_rt_i && (id_ex_rt_i == id_rt_i)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= RUN;
            md_cnt_reg <= '0;
        end else if (branch_taken_i) begin
            state_reg  <= RUN;
            md_cnt_reg <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (md_start_i) begin
                        state_reg  <= MD_BUSY;
                        md_cnt_reg <= MD_RELOAD;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt_reg == '0) begin
                        state_reg <= RUN;
                    end else begin
                        md_cnt_reg <= md_cnt_reg - MD_CNT_W'(1);
                    end
                end
                default: begin
                    state_reg  <= RUN;
                    md_cnt_reg <= '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        id_ex_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        md_done_o      = 1'b0;
        md_abort_o     = 1'b0;
        if (rst_i) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
        end else if (branch_taken_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            md_abort_o     = in_busy || md_start_i;
        end else if (in_busy || md_start_i) begin
            // Freeze the front end and feed bubbles into MEM while EX is occupied.
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            ex_mem_flush_o = 1'b1;
            md_done_o      = in_busy && (md_cnt_reg == '0);
        end else if (load_use) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_flush_o = 1'b1;
        end
    end

    assign busy_o = in_busy && !rst_i;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk  (clk_i),
        .srst (rst_i),
        .clr  (cnt_clr_i),
        .inc  (!pc_write_o),
        .q    (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk  (clk_i),
        .srst (rst_i),
        .clr  (cnt_clr_i),
        .inc  (branch_taken_i),
        .q    (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each driven cycle pushes its expected outputs,
// a sampler pops and compares them just before the next rising edge.
module tb_hazard_ctrl;

    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CMAX = '1;

    // {pc_w, if_id_w, id_ex_w, if_id_fl, id_ex_fl, ex_mem_fl, done, abort, busy}
    localparam logic [8:0] C_RUN  = 9'b111_000_000;
    localparam logic [8:0] C_RST  = 9'b000_111_000;
    localparam logic [8:0] C_LU   = 9'b001_010_000;
    localparam logic [8:0] C_MDI  = 9'b000_001_000;
    localparam logic [8:0] C_MDB  = 9'b000_001_001;
    localparam logic [8:0] C_MDD  = 9'b000_001_101;
    localparam logic [8:0] C_BR   = 9'b111_111_000;
    localparam logic [8:0] C_BRMI = 9'b111_111_010;
    localparam logic [8:0] C_BRMB = 9'b111_111_011;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic [4:0] id_rs_i = '0, id_rt_i = '0, id_ex_rt_i = '0;
    logic id_uses_rt_i = 1'b0, id_ex_memread_i = 1'b0, md_start_i = 1'b0;
    logic branch_taken_i = 1'b0, cnt_clr_i = 1'b0;
    logic pc_write_o, if_id_write_o, id_ex_write_o;
    logic if_id_flush_o, id_ex_flush_o, ex_mem_flush_o;
    logic md_done_o, md_abort_o, busy_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    typedef struct {
        string            tag;
        logic [8:0]       ctrl;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    exp_t exp_q[$];
    logic [CNT_W-1:0] m_stall = '0, m_flush = '0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .id_rs_i         (id_rs_i),
        .id_rt_i         (id_rt_i),
        .id_uses_rt_i    (id_uses_rt_i),
        .id_ex_rt_i      (id_ex_rt_i),
        .id_ex_memread_i (id_ex_memread_i),
        .md_start_i      (md_start_i),
        .branch_taken_i  (branch_taken_i),
        .cnt_clr_i       (cnt_clr_i),
        .pc_write_o      (pc_write_o),
        .if_id_write_o   (if_id_write_o),
        .id_ex_write_o   (id_ex_write_o),
        .if_id_flush_o   (if_id_flush_o),
        .id_ex_flush_o   (id_ex_flush_o),
        .ex_mem_flush_o  (ex_mem_flush_o),
        .md_done_o       (md_done_o),
        .md_abort_o      (md_abort_o),
        .busy_o          (busy_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the DUT must show.
    task automatic step(input string tag, input logic rst, input logic [4:0] rs,
                        input logic [4:0] rt, input logic uses_rt, input logic [4:0] ex_rt,
                        input logic memrd, input logic md, input logic br, input logic clr,
                        input logic [8:0] ctrl);
        exp_t e;
        @(negedge clk);
        rst_i = rst; id_rs_i = rs; id_rt_i = rt; id_uses_rt_i = uses_rt;
        id_ex_rt_i = ex_rt; id_ex_memread_i = memrd; md_start_i = md;
        branch_taken_i = br; cnt_clr_i = clr;
        e.tag = tag; e.ctrl = ctrl; e.stall = m_stall; e.flush = m_flush;
        exp_q.push_back(e);
        if (rst || clr) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (!ctrl[8] && m_stall != CMAX) m_stall = m_stall + 1'b1;
            if (br && m_flush != CMAX) m_flush = m_flush + 1'b1;
        end
    endtask

    task automatic idle(input string tag, input logic [8:0] ctrl);
        step(tag, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, ctrl);
    endtask

    always begin
        @(negedge clk);
        #4;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, "_ctrl"}, 32'({pc_write_o, if_id_write_o, id_ex_write_o,
                  if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
                  md_done_o, md_abort_o, busy_o}), 32'(e.ctrl));
            check({e.tag, "_stall_cnt"}, 32'(stall_cnt_o), 32'(e.stall));
            check({e.tag, "_flush_cnt"}, 32'(flush_cnt_o), 32'(e.flush));
            $display("cycle %s ctrl=%b stall=%0d flush=%0d", e.tag,
                     {pc_write_o, if_id_write_o, id_ex_write_o, if_id_flush_o,
                      id_ex_flush_o, ex_mem_flush_o, md_done_o, md_abort_o, busy_o},
                     stall_cnt_o, flush_cnt_o);
        end
    end

    initial begin
        step("reset0", 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_RST);
        step("reset1", 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_RST);
        idle("run_idle", C_RUN);

        // Load-use hazards and the $0 / unused-rt exemptions.
        step("lu_rs", 0, 5'd2, 5'd7, 0, 5'd2, 1, 0, 0, 0, C_LU);
        idle("lu_after", C_RUN);
        step("lu_zero", 0, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, C_RUN);
        step("lu_rt_unused", 0, 5'd1, 5'd3, 0, 5'd3, 1, 0, 0, 0, C_RUN);
        step("lu_rt_used", 0, 5'd1, 5'd3, 1, 5'd3, 1, 0, 0, 0, C_LU);
        step("lu_nomatch", 0, 5'd4, 5'd5, 1, 5'd6, 1, 0, 0, 0, C_RUN);

        // Full mult/div occupancy; md_start held high while busy is ignored.
        step("md_clr", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, C_RUN);
        step("md_c1", 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, C_MDI);
        step("md_c2", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_MDB);
        step("md_c3", 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, C_MDB);
        step("md_c4", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_MDD);
        idle("md_after", C_RUN);

        // Branch kills an in-flight mult/div, then branches in RUN.
        step("ab_clr", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, C_RUN);
        step("ab_c1", 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, C_MDI);
        step("ab_br", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, C_BRMB);
        idle("ab_after", C_RUN);
        idle("ab_after2", C_RUN);
        step("br_run", 0, 5'd2, 5'd0, 0, 5'd2, 1, 0, 1, 0, C_BR);
        step("br_mdstart", 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, C_BRMI);
        idle("br_after", C_RUN);

        // Reset in the middle of MD_BUSY abandons the op without abort.
        step("rm_c1", 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, C_MDI);
        step("rm_c2", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_MDB);
        step("rm_rst", 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_RST);
        idle("rm_after", C_RUN);

        // Counter saturation, then clear winning over a same-cycle stall.
        for (int i = 0; i < 20; i++)
            step($sformatf("sat_lu%0d", i), 0, 5'd9, 5'd0, 0, 5'd9, 1, 0, 0, 0, C_LU);
        for (int i = 0; i < 17; i++)
            step($sformatf("sat_br%0d", i), 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, C_BR);
        idle("sat_hold", C_RUN);
        step("clr_stall", 0, 5'd9, 5'd0, 0, 5'd9, 1, 0, 0, 1, C_LU);
        idle("clr_after", C_RUN);

        repeat (3) @(negedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
